swipt_session_ctrl: RTL and testbench

Sequences one SWIPT data session: startup preamble, payload transmit, then receive window.
It drives the startup_data / data_trans / data_rec phase enables, latches the nominal duty word, and selects the bit driven onto d.
It sits between Optimization (data_start), StartupData, DataStream, ReadData, CalcL and DutyAdjust, in place of ad-hoc edge-triggered phase registers.
It adds a receive timeout with bounded retransmission and a heartbeat-loss abort.

---
 rtl/swipt_session_ctrl_pkg.sv | 22 ++
 rtl/swipt_session_ctrl_if.sv | 42 ++++
 rtl/swipt_session_ctrl_timeout_cnt.sv | 29 ++
 rtl/swipt_session_ctrl.sv | 121 ++++++++++++
 tb/tb_swipt_session_ctrl.sv | 385 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/swipt_session_ctrl_pkg.sv
// Shared definitions for the SWIPT session controller: state encoding and default duty word width.
package swipt_session_ctrl_pkg;

  localparam int LW_DEFAULT = 12;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_STARTUP  = 3'd1;
  localparam logic [2:0] ST_TRANSMIT = 3'd2;
  localparam logic [2:0] ST_RECEIVE  = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;
  localparam logic [2:0] ST_ERROR    = 3'd5;

  typedef enum logic [2:0] {
    IDLE     = ST_IDLE,
    STARTUP  = ST_STARTUP,
    TRANSMIT = ST_TRANSMIT,
    RECEIVE  = ST_RECEIVE,
    DONE     = ST_DONE,
    ERROR    = ST_ERROR
  } state_e;

endpackage

// File: rtl/swipt_session_ctrl_if.sv
// Session handshake bundle between the SWIPT phase blocks and the session controller.
interface swipt_session_ctrl_if
  import swipt_session_ctrl_pkg::*;
#(
  parameter int LW = LW_DEFAULT
);

  logic          swipt_alive;
  logic          data_start;
  logic          startup_compl;
  logic          data_t_done;
  logic          rx_read;
  logic [LW-1:0] l_in;
  logic          d_startup;
  logic          d_data;

  logic          startup_data;
  logic          data_trans;
  logic          data_rec;
  logic          d;
  logic [LW-1:0] l_def;
  logic          busy;
  logic [1:0]    retry_cnt;
  logic          session_done;
  logic          session_err;

  // The environment (phase blocks) is the master; the controller is the slave.
  modport master (
    output swipt_alive, data_start, startup_compl, data_t_done, rx_read,
           l_in, d_startup, d_data,
    input  startup_data, data_trans, data_rec, d, l_def, busy, retry_cnt,
           session_done, session_err
  );

  modport slave (
    input  swipt_alive, data_start, startup_compl, data_t_done, rx_read,
           l_in, d_startup, d_data,
    output startup_data, data_trans, data_rec, d, l_def, busy, retry_cnt,
           session_done, session_err
  );

endinterface

// File: rtl/swipt_session_ctrl_timeout_cnt.sv
// Saturating timeout counter; expired flags the last counted cycle while enabled.
module swipt_timeout_cnt #(
  parameter int LIMIT = 2
) (
  input  logic clk,
  input  logic nrst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int            W    = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0]  Last = W'(LIMIT - 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != Last)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign expired = en && (cnt_q == Last);

endmodule

// File: rtl/swipt_session_ctrl.sv
// SWIPT session sequencer: startup preamble, payload transmit, receive window with
// bounded retransmission and heartbeat-loss abort.
module swipt_session_ctrl
  import swipt_session_ctrl_pkg::*;
#(
  parameter int LW            = LW_DEFAULT,
  parameter int RX_TIMEOUT    = 50000,
  parameter int ALIVE_TIMEOUT = 100000,
  parameter int MAX_RETRY     = 3
) (
  input logic                 clk,
  input logic                 nrst,
  swipt_session_ctrl_if.slave bus
);

  localparam logic [1:0] MaxRetry = 2'(MAX_RETRY);

  state_e        state_q;
  logic [LW-1:0] l_def_q;
  logic [1:0]    retry_cnt_q;
  logic          d_q;
  logic          d_d;

  logic start_q, compl_q, tdone_q, read_q;
  logic start_edge, compl_edge, tdone_edge, read_edge;
  logic active, in_rx, rx_expired, alive_expired;

  assign start_edge = bus.data_start    & ~start_q;
  assign compl_edge = bus.startup_compl & ~compl_q;
  assign tdone_edge = bus.data_t_done   & ~tdone_q;
  assign read_edge  = bus.rx_read       & ~read_q;

  assign in_rx  = (state_q == RECEIVE);
  assign active = (state_q == STARTUP) || (state_q == TRANSMIT) || in_rx;

  // The rx window counter is held clear outside RECEIVE, so every entry starts from zero.
  swipt_timeout_cnt #(.LIMIT(RX_TIMEOUT)) u_rx_cnt (
    .clk     (clk),
    .nrst    (nrst),
    .clr     (~in_rx),
    .en      (in_rx),
    .expired (rx_expired)
  );

  swipt_timeout_cnt #(.LIMIT(ALIVE_TIMEOUT)) u_alive_cnt (
    .clk     (clk),
    .nrst    (nrst),
    .clr     (~active | bus.swipt_alive),
    .en      (active & ~bus.swipt_alive),
    .expired (alive_expired)
  );

  assign d_d = (state_q == STARTUP)  ? bus.d_startup :
               (state_q == TRANSMIT) ? bus.d_data    : 1'b0;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= IDLE;
      l_def_q     <= '0;
      retry_cnt_q <= '0;
      d_q         <= 1'b0;
      start_q     <= 1'b0;
      compl_q     <= 1'b0;
      tdone_q     <= 1'b0;
      read_q      <= 1'b0;
    end else begin
      start_q <= bus.data_start;
      compl_q <= bus.startup_compl;
      tdone_q <= bus.data_t_done;
      read_q  <= bus.rx_read;
      d_q     <= d_d;

      // Heartbeat loss overrides every phase event.
      if (alive_expired) begin
        state_q <= ERROR;
      end else begin
        case (state_q)
          IDLE: begin
            if (start_edge) begin
              state_q     <= STARTUP;
              l_def_q     <= bus.l_in;
              retry_cnt_q <= '0;
            end
          end
          STARTUP: begin
            if (compl_edge) state_q <= TRANSMIT;
          end
          TRANSMIT: begin
            if (tdone_edge) state_q <= RECEIVE;
          end
          RECEIVE: begin
            if (read_edge) begin
              state_q <= DONE;
            end else if (rx_expired) begin
              if (retry_cnt_q < MaxRetry) begin
                retry_cnt_q <= retry_cnt_q + 2'd1;
                state_q     <= TRANSMIT;
              end else begin
                state_q <= ERROR;
              end
            end
          end
          DONE:    state_q <= IDLE;
          ERROR:   state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.startup_data = (state_q == STARTUP);
  assign bus.data_trans   = (state_q == TRANSMIT);
  assign bus.data_rec     = in_rx;
  assign bus.busy         = (state_q != IDLE);
  assign bus.session_done = (state_q == DONE);
  assign bus.session_err  = (state_q == ERROR);
  assign bus.d            = d_q;
  assign bus.l_def        = l_def_q;
  assign bus.retry_cnt    = retry_cnt_q;

endmodule

// File: tb/tb_swipt_session_ctrl.sv
// Self-checking bench for swipt_session_ctrl: scenario tasks plus a randomized run,
// all compared against a phase-level reference model.
module tb_swipt_session_ctrl;

  localparam int LW            = 12;
  localparam int RX_TIMEOUT    = 8;
  localparam int ALIVE_TIMEOUT = 16;
  localparam int MAX_RETRY     = 2;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  swipt_session_ctrl_if #(.LW(LW)) bus();

  swipt_session_ctrl #(
    .LW            (LW),
    .RX_TIMEOUT    (RX_TIMEOUT),
    .ALIVE_TIMEOUT (ALIVE_TIMEOUT),
    .MAX_RETRY     (MAX_RETRY)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference model: session phase plus plain integer bookkeeping of time spent.
  typedef enum int {P_IDLE, P_PRE, P_TX, P_RX, P_OK, P_FAIL} ph_t;
  ph_t           mPh = P_IDLE;
  ph_t           nxt;
  int            mRxSpent = 0, mLowRun = 0, mRetries = 0, lowRun;
  logic [LW-1:0] mLdef = '0;
  logic          mD = 1'b0;
  logic          pStart = 0, pCompl = 0, pDone = 0, pRead = 0;
  logic          eStart, eCompl, eDone, eRead, mActive;

  always @(posedge clk) begin
    if (!nrst) begin
      mPh = P_IDLE; mRxSpent = 0; mLowRun = 0; mRetries = 0; mLdef = '0; mD = 1'b0;
      pStart = 0; pCompl = 0; pDone = 0; pRead = 0;
    end else begin
      eStart  = bus.data_start    && !pStart;
      eCompl  = bus.startup_compl && !pCompl;
      eDone   = bus.data_t_done   && !pDone;
      eRead   = bus.rx_read       && !pRead;
      mActive = (mPh == P_PRE) || (mPh == P_TX) || (mPh == P_RX);
      lowRun  = (mActive && !bus.swipt_alive) ? mLowRun + 1 : 0;
      mD      = (mPh == P_PRE) ? bus.d_startup : (mPh == P_TX) ? bus.d_data : 1'b0;
      nxt     = mPh;
      if (lowRun >= ALIVE_TIMEOUT) begin
        nxt = P_FAIL;
      end else begin
        case (mPh)
          P_IDLE: if (eStart) begin nxt = P_PRE; mLdef = bus.l_in; mRetries = 0; end
          P_PRE:  if (eCompl) nxt = P_TX;
          P_TX:   if (eDone) begin nxt = P_RX; mRxSpent = 0; end
          P_RX: begin
            mRxSpent = mRxSpent + 1;
            if (eRead) nxt = P_OK;
            else if (mRxSpent >= RX_TIMEOUT) begin
              if (mRetries < MAX_RETRY) begin mRetries = mRetries + 1; nxt = P_TX; end
              else nxt = P_FAIL;
            end
          end
          default: nxt = P_IDLE;
        endcase
      end
      mLowRun = lowRun;
      mPh     = nxt;
      pStart  = bus.data_start; pCompl = bus.startup_compl;
      pDone   = bus.data_t_done; pRead = bus.rx_read;
    end
  end

  function automatic logic [LW+8:0] model_vec();
    return {mPh == P_PRE, mPh == P_TX, mPh == P_RX, mPh != P_IDLE, mPh == P_OK,
            mPh == P_FAIL, 2'(mRetries), mD, mLdef};
  endfunction

  function automatic logic [LW+8:0] dut_vec();
    return {bus.startup_data, bus.data_trans, bus.data_rec, bus.busy, bus.session_done,
            bus.session_err, bus.retry_cnt, bus.d, bus.l_def};
  endfunction

  function automatic logic [2:0] phases();
    return {bus.startup_data, bus.data_trans, bus.data_rec};
  endfunction

  task automatic drive_quiet();
    bus.data_start = 0; bus.startup_compl = 0; bus.data_t_done = 0; bus.rx_read = 0;
    bus.d_startup = 0; bus.d_data = 0; bus.swipt_alive = 1; bus.l_in = '0;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    drive_quiet();
    repeat (3) @(negedge clk);
    checks++;
    if (dut_vec() !== '0) begin
      errors++; $display("[TB] FAIL reset_zero: got %h expected 0", dut_vec());
    end
    checks++;
    if (dut_vec() !== model_vec()) begin
      errors++; $display("[TB] FAIL reset_model: got %h expected %h", dut_vec(), model_vec());
    end
    nrst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_idle_busy: got %b expected 0", bus.busy);
    end
  endtask

  task automatic test_nominal();
    int doneCnt = 0;
    for (int i = 0; i < 35; i++) begin
      bus.data_start    = (i == 0);
      bus.startup_compl = (i == 6);
      bus.data_t_done   = (i == 26);
      bus.rx_read       = (i == 29);
      bus.l_in          = (i == 0) ? 12'h12C : LW'($urandom);
      bus.d_startup     = 1'($urandom);
      bus.d_data        = 1'($urandom);
      @(negedge clk);
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("[TB] FAIL nominal_model cyc=%0d: got %h expected %h", i, dut_vec(), model_vec());
      end
      doneCnt += int'(bus.session_done);
      if (i == 0 || i == 6 || i == 26) begin
        checks++;
        if (phases() !== ((i == 0) ? 3'b100 : (i == 6) ? 3'b010 : 3'b001)) begin
          errors++; $display("[TB] FAIL nominal_phase cyc=%0d: got %b", i, phases());
        end
      end
    end
    checks++;
    if (doneCnt != 1) begin
      errors++; $display("[TB] FAIL nominal_done_count: got %0d expected 1", doneCnt);
    end
    checks++;
    if ({bus.l_def, bus.retry_cnt, bus.busy} !== {12'h12C, 2'd0, 1'b0}) begin
      errors++; $display("[TB] FAIL nominal_end: l_def=%h retry=%0d busy=%b expected 12c/0/0",
                         bus.l_def, bus.retry_cnt, bus.busy);
    end
  endtask

  task automatic test_bit_select();
    logic srcBit;
    for (int i = 0; i < 30; i++) begin
      bus.data_start    = (i == 0);
      bus.startup_compl = (i == 8);
      bus.data_t_done   = (i == 16);
      bus.rx_read       = (i == 24);
      bus.l_in          = LW'($urandom);
      bus.d_startup     = (i < 9)  ? ~bus.d_startup : 1'b1;
      bus.d_data        = (i >= 9) ? ~bus.d_data    : 1'b1;
      srcBit            = (i < 9) ? bus.d_startup : bus.d_data;
      @(negedge clk);
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("[TB] FAIL bitsel_model cyc=%0d: got %h expected %h", i, dut_vec(), model_vec());
      end
      if (i >= 1) begin
        checks++;
        if (bus.d !== ((i <= 16) ? srcBit : 1'b0)) begin
          errors++; $display("[TB] FAIL bitsel_d cyc=%0d: got %b expected %b", i, bus.d,
                             (i <= 16) ? srcBit : 1'b0);
        end
      end
    end
  endtask

  task automatic test_retry_error();
    int rxRun = 0, rxVisits = 0, errCnt = 0;
    for (int i = 0; i < 37; i++) begin
      bus.data_start    = (i == 0);
      bus.startup_compl = (i == 2);
      bus.data_t_done   = (i == 4) || (i == 14) || (i == 25);
      bus.rx_read       = 1'b0;
      bus.l_in          = LW'($urandom);
      bus.d_startup     = 1'($urandom);
      bus.d_data        = 1'($urandom);
      @(negedge clk);
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("[TB] FAIL retry_model cyc=%0d: got %h expected %h", i, dut_vec(), model_vec());
      end
      errCnt += int'(bus.session_err);
      if (bus.data_rec) rxRun++;
      else if (rxRun > 0) begin
        rxVisits++;
        checks++;
        if (rxRun != RX_TIMEOUT) begin
          errors++; $display("[TB] FAIL retry_rx_len visit=%0d: got %0d expected %0d", rxVisits, rxRun, RX_TIMEOUT);
        end
        rxRun = 0;
      end
      if (i == 12 || i == 22) begin
        checks++;
        if ({bus.data_trans, bus.retry_cnt} !== {1'b1, (i == 12) ? 2'd1 : 2'd2}) begin
          errors++; $display("[TB] FAIL retry_count cyc=%0d: got trans=%b retry=%0d", i, bus.data_trans, bus.retry_cnt);
        end
      end
      if (i == 33) begin
        checks++;
        if (bus.session_err !== 1'b1) begin
          errors++; $display("[TB] FAIL retry_err_pulse: got %b expected 1", bus.session_err);
        end
      end
    end
    checks++;
    if (rxVisits != 3 || errCnt != 1 || bus.busy !== 1'b0) begin
      errors++; $display("[TB] FAIL retry_summary: visits=%0d errs=%0d busy=%b expected 3/1/0", rxVisits, errCnt, bus.busy);
    end
  endtask

  task automatic test_heartbeat();
    int errCnt = 0;
    for (int i = 0; i < 55; i++) begin
      bus.data_start    = (i == 0) || (i == 22);
      bus.startup_compl = (i == 2) || (i == 24);
      bus.data_t_done   = (i == 46);
      bus.rx_read       = (i == 48);
      bus.swipt_alive   = !((i >= 4 && i <= 19) || (i >= 26 && i <= 40));
      bus.l_in          = LW'($urandom);
      bus.d_startup     = 1'($urandom);
      bus.d_data        = 1'($urandom);
      @(negedge clk);
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("[TB] FAIL alive_model cyc=%0d: got %h expected %h", i, dut_vec(), model_vec());
      end
      errCnt += int'(bus.session_err);
      if (i == 18 || i == 19) begin
        checks++;
        if (bus.session_err !== (i == 19)) begin
          errors++; $display("[TB] FAIL alive_abort cyc=%0d: got %b expected %b", i, bus.session_err, i == 19);
        end
      end
      if (i == 45) begin
        checks++;
        if (bus.data_trans !== 1'b1) begin
          errors++; $display("[TB] FAIL alive_15_low_survives: got trans=%b expected 1", bus.data_trans);
        end
      end
      if (i == 48) begin
        checks++;
        if (bus.session_done !== 1'b1) begin
          errors++; $display("[TB] FAIL alive_second_done: got %b expected 1", bus.session_done);
        end
      end
    end
    bus.swipt_alive = 1'b1;
    checks++;
    if (errCnt != 1) begin
      errors++; $display("[TB] FAIL alive_err_count: got %0d expected 1", errCnt);
    end
  endtask

  task automatic test_simultaneous();
    logic [LW-1:0] lB;
    lB = LW'($urandom);
    for (int i = 0; i < 28; i++) begin
      bus.data_start    = (i == 0) || (i == 16) || (i == 20);
      bus.startup_compl = (i == 2) || (i == 18);
      bus.data_t_done   = (i == 4) || (i == 22);
      bus.rx_read       = (i == 12) || (i == 24);
      bus.l_in          = (i == 16) ? lB : (i == 20) ? ~lB : LW'($urandom);
      bus.d_startup     = 1'($urandom);
      bus.d_data        = 1'($urandom);
      @(negedge clk);
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("[TB] FAIL simul_model cyc=%0d: got %h expected %h", i, dut_vec(), model_vec());
      end
      if (i == 12) begin
        checks++;
        if ({bus.session_done, bus.data_trans, bus.retry_cnt} !== 4'b1000) begin
          errors++; $display("[TB] FAIL simul_read_beats_timeout: done=%b trans=%b retry=%0d expected 1/0/0",
                             bus.session_done, bus.data_trans, bus.retry_cnt);
        end
      end
      if (i == 20 || i == 21 || i == 27) begin
        checks++;
        if (bus.l_def !== lB) begin
          errors++; $display("[TB] FAIL simul_ldef_hold cyc=%0d: got %h expected %h", i, bus.l_def, lB);
        end
      end
      if (i == 21) begin
        checks++;
        if (phases() !== 3'b010) begin
          errors++; $display("[TB] FAIL simul_busy_start_ignored: got %b expected 010", phases());
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [LW-1:0] lNew = '0;
    int errCnt = 0;
    for (int i = 0; i < 25; i++) begin
      nrst              = (i != 16);
      bus.data_start    = (i == 0) || (i == 18);
      bus.startup_compl = (i == 2) || (i == 20);
      bus.data_t_done   = (i == 4) || (i == 14);
      bus.rx_read       = 1'b0;
      bus.l_in          = LW'($urandom);
      if (i == 18) lNew = bus.l_in;
      bus.d_startup     = 1'($urandom);
      bus.d_data        = 1'($urandom);
      @(negedge clk);
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("[TB] FAIL mreset_model cyc=%0d: got %h expected %h", i, dut_vec(), model_vec());
      end
      errCnt += int'(bus.session_err);
      if (i == 15) begin
        checks++;
        if ({bus.data_rec, bus.retry_cnt} !== 3'b101) begin
          errors++; $display("[TB] FAIL mreset_setup: rec=%b retry=%0d expected 1/1", bus.data_rec, bus.retry_cnt);
        end
      end
      if (i == 16) begin
        checks++;
        if (dut_vec() !== '0) begin
          errors++; $display("[TB] FAIL mreset_zero: got %h expected 0", dut_vec());
        end
      end
      if (i == 18) begin
        checks++;
        if ({bus.startup_data, bus.retry_cnt, bus.l_def} !== {1'b1, 2'd0, lNew}) begin
          errors++; $display("[TB] FAIL mreset_restart: start=%b retry=%0d l_def=%h expected 1/0/%h",
                             bus.startup_data, bus.retry_cnt, bus.l_def, lNew);
        end
      end
    end
    nrst = 1'b1;
    checks++;
    if (errCnt != 0 || bus.data_trans !== 1'b1) begin
      errors++; $display("[TB] FAIL mreset_silent: errs=%0d trans=%b expected 0/1", errCnt, bus.data_trans);
    end
  endtask

  task automatic test_random();
    int outage = 0;
    for (int i = 0; i < 900; i++) begin
      nrst              = ($urandom_range(0, 399) != 0);
      bus.data_start    = ($urandom_range(0, 7) == 0);
      bus.startup_compl = ($urandom_range(0, 3) == 0);
      bus.data_t_done   = ($urandom_range(0, 3) == 0);
      bus.rx_read       = ($urandom_range(0, 11) == 0);
      if (outage == 0 && $urandom_range(0, 59) == 0) outage = $urandom_range(10, 20);
      bus.swipt_alive   = (outage == 0) && ($urandom_range(0, 9) != 0);
      if (outage > 0) outage--;
      bus.l_in          = LW'($urandom);
      bus.d_startup     = 1'($urandom);
      bus.d_data        = 1'($urandom);
      @(negedge clk);
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("[TB] FAIL random_model cyc=%0d: got %h expected %h", i, dut_vec(), model_vec());
      end
    end
    nrst = 1'b1;
  endtask

  initial begin
    drive_quiet();
    test_reset();
    test_nominal();
    test_bit_select();
    test_retry_error();
    test_heartbeat();
    test_simultaneous();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
